// File: rtl/window_3x3.sv
// -----------------------------------------------------------------------------
// window_3x3
//   Builds a 3x3 pixel neighbourhood from a raster-order pixel stream using two
//   line buffers and a 3x3 shift register. A window is flagged only once it is
//   fully populated with pixels from the current frame, so border windows
//   (those that would straddle a row or frame edge) are never emitted.
//
// Parameters
//   DATA_W : pixel width in bits
//   IMG_W  : pixels per row (>= 3)
//   IMG_H  : rows per frame (>= 3)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   tstart     : frame-start pulse, honoured only while idle
//   pix_valid  : pix_data carries a pixel this cycle
//   pix_data   : raster-order pixel
//   win_data   : registered window, [row][col], row 0 oldest line, col 0 oldest column
//   win_valid  : one-cycle pulse, win_data holds a new complete window
//   busy       : high while a frame is being streamed
//   frame_done : one-cycle pulse with the last window of the frame
// -----------------------------------------------------------------------------
module window_3x3 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tstart,
  input  logic                          pix_valid,
  input  logic [DATA_W-1:0]             pix_data,
  output logic [2:0][2:0][DATA_W-1:0]   win_data,
  output logic                          win_valid,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                        state_reg;
  logic [COL_W-1:0]              col_reg;
  logic [ROW_W-1:0]              row_reg;
  logic                          win_valid_reg;
  logic                          busy_reg;
  logic                          frame_done_reg;
  logic [2:0][2:0][DATA_W-1:0]   win_reg;

  // lb0 holds the previous row, lb1 the row before that. Their contents are
  // never reset: anything stale is overwritten before a window can use it.
  logic [DATA_W-1:0]             lb0 [IMG_W];
  logic [DATA_W-1:0]             lb1 [IMG_W];

  logic                          accept;
  logic [2:0][DATA_W-1:0]        col_new;

  assign accept = (state_reg == STREAM) && pix_valid;

  // Newest column of the window: top = two rows up, bottom = incoming pixel.
  assign col_new[0] = lb1[col_reg];
  assign col_new[1] = lb0[col_reg];
  assign col_new[2] = pix_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_reg] <= lb0[col_reg];
      lb0[col_reg] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      win_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      win_reg        <= '0;
    end else begin
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tstart) begin
            state_reg <= STREAM;
            busy_reg  <= 1'b1;
            col_reg   <= '0;
            row_reg   <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            for (int i = 0; i < 3; i++) begin
              win_reg[i][0] <= win_reg[i][1];
              win_reg[i][1] <= win_reg[i][2];
              win_reg[i][2] <= col_new[i];
            end
            // Only windows whose three columns all lie in this row and whose
            // three rows all lie in this frame are flagged.
            win_valid_reg <= (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
            if (col_reg == COL_LAST) begin
              col_reg <= '0;
              if (row_reg == ROW_LAST) begin
                row_reg        <= '0;
                state_reg      <= IDLE;
                busy_reg       <= 1'b0;
                frame_done_reg <= 1'b1;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign win_data   = win_reg;
  assign win_valid  = win_valid_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window_3x3.sv
module tb_window_3x3;

  localparam int DW = 32;
  localparam int W  = 5;
  localparam int H  = 5;

  typedef logic [2:0][2:0][DW-1:0] win_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tstart;
  logic         pix_valid;
  logic [DW-1:0] pix_data;
  win_t         win_data;
  logic         win_valid;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  // Per-frame recording filled by the stimulus helper, judged by each test.
  win_t win_cap [16];
  int   win_pix [16];
  int   win_cnt;
  int   fd_cnt;
  int   gap_viol;
  bit   fd_ok;
  logic busy_end;

  window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tstart    (tstart),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  function automatic win_t mk_win(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
    win_t w;
    w[0][0] = DW'(a0); w[0][1] = DW'(a1); w[0][2] = DW'(a2);
    w[1][0] = DW'(b0); w[1][1] = DW'(b1); w[1][2] = DW'(b2);
    w[2][0] = DW'(c0); w[2][1] = DW'(c1); w[2][2] = DW'(c2);
    return w;
  endfunction

  // Window n of a frame (raster order among interior centres); pixel value
  // is offset + row*5 + col, window completed at pixel (2+n/3, 2+n%3).
  function automatic win_t exp_win(input int offset, input int n);
    win_t w;
    int r, c;
    r = 2 + n / 3;
    c = 2 + n % 3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = DW'(offset + (r - 2 + i) * W + (c - 2 + j));
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    win_cnt  = 0;
    fd_cnt   = 0;
    gap_viol = 0;
    fd_ok    = 1'b0;
    busy_end = 1'bx;
    for (int i = 0; i < 16; i++) begin
      win_cap[i] = 'x;
      win_pix[i] = -1;
    end
  endtask

  task automatic send_start();
    tstart    = 1'b1;
    pix_valid = 1'b0;
    step();
    tstart    = 1'b0;
  endtask

  task automatic stream(input int offset, input int n_pix, input bit gaps, input int tst_at);
    win_t prev;
    int   ng;
    for (int k = 0; k < n_pix; k++) begin
      ng = 0;
      if (gaps) ng = (k % 3 == 0) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        pix_valid = 1'b0;
        pix_data  = 32'hDEAD_BEEF;
        prev      = win_data;
        step();
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== prev) gap_viol++;
      end
      pix_valid = 1'b1;
      pix_data  = DW'(offset + k);
      tstart    = (k == tst_at);
      step();
      tstart    = 1'b0;
      pix_valid = 1'b0;
      if (win_valid === 1'b1) begin
        if (win_cnt < 16) begin
          win_cap[win_cnt] = win_data;
          win_pix[win_cnt] = k;
        end
        win_cnt++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_ok = (k == W * H - 1) && (win_valid === 1'b1);
      end
      if (k == n_pix - 1) busy_end = busy;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    tstart    = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 32'd7;
    step(); step(); step();
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h expected 0", win_data); end
    pix_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_no_tstart();
    int v_hits, b_hits;
    v_hits = 0;
    b_hits = 0;
    for (int k = 0; k < 2 * W + 2; k++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(k);
      step();
      if (win_valid !== 1'b0) v_hits++;
      if (busy !== 1'b0) b_hits++;
    end
    pix_valid = 1'b0;
    checks++; if (v_hits != 0) begin errors++; $display("FAIL no_tstart_win_valid: got %0d pulses expected 0", v_hits); end
    checks++; if (b_hits != 0) begin errors++; $display("FAIL no_tstart_busy: got %0d busy cycles expected 0", b_hits); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL no_tstart_win_data: got %h expected 0", win_data); end
    $display("test_no_tstart done");
  endtask

  task automatic test_full_frame();
    win_t w;
    clear_rec();
    send_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_start: got %b expected 1", busy); end
    stream(0, W * H, 1'b0, -1);
    checks++; if (win_cnt != 9) begin errors++; $display("FAIL full_count: got %0d expected 9", win_cnt); end
    checks++; if (win_pix[0] != 12) begin errors++; $display("FAIL full_first_pos: got pixel %0d expected 12", win_pix[0]); end
    w = mk_win(0, 1, 2, 5, 6, 7, 10, 11, 12);
    checks++; if (win_cap[0] !== w) begin errors++; $display("FAIL full_first_win: got %h expected %h", win_cap[0], w); end
    w = mk_win(12, 13, 14, 17, 18, 19, 22, 23, 24);
    checks++; if (win_cap[8] !== w) begin errors++; $display("FAIL full_last_win: got %h expected %h", win_cap[8], w); end
    for (int n = 0; n < 9; n++) begin
      w = exp_win(0, n);
      checks++; if (win_cap[n] !== w) begin errors++; $display("FAIL full_win%0d: got %h expected %h", n, win_cap[n], w); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL full_fd_count: got %0d expected 1", fd_cnt); end
    checks++; if (fd_ok !== 1'b1) begin errors++; $display("FAIL full_fd_with_last: got %b expected 1", fd_ok); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy_end); end
    $display("test_full_frame done");
  endtask

  task automatic test_gaps();
    win_t w;
    clear_rec();
    send_start();
    stream(0, W * H, 1'b1, -1);
    checks++; if (win_cnt != 9) begin errors++; $display("FAIL gaps_count: got %0d expected 9", win_cnt); end
    for (int n = 0; n < 9; n++) begin
      w = exp_win(0, n);
      checks++; if (win_cap[n] !== w) begin errors++; $display("FAIL gaps_win%0d: got %h expected %h", n, win_cap[n], w); end
    end
    checks++; if (gap_viol != 0) begin errors++; $display("FAIL gaps_stable: got %0d changes expected 0", gap_viol); end
    checks++; if (fd_cnt != 1 || fd_ok !== 1'b1) begin errors++; $display("FAIL gaps_fd: got count %0d ok %b expected 1 1", fd_cnt, fd_ok); end
    $display("test_gaps done");
  endtask

  task automatic test_async_reset();
    win_t w;
    clear_rec();
    send_start();
    stream(0, 14, 1'b0, -1);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", win_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL areset_win_valid: got %b expected 0", win_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL areset_win_data: got %h expected 0", win_data); end
    #1 rst_n = 1'b1;
    clear_rec();
    send_start();
    stream(0, W * H, 1'b0, -1);
    checks++; if (win_cnt != 9) begin errors++; $display("FAIL areset_count: got %0d expected 9", win_cnt); end
    for (int n = 0; n < 9; n++) begin
      w = exp_win(0, n);
      checks++; if (win_cap[n] !== w) begin errors++; $display("FAIL areset_win%0d: got %h expected %h", n, win_cap[n], w); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    win_t w;
    clear_rec();
    send_start();
    stream(0, W * H, 1'b0, -1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_fd1: got %b expected 1", frame_done); end
    // tstart raised during the frame_done cycle, sampled while idle.
    clear_rec();
    send_start();
    stream(100, W * H, 1'b0, -1);
    w = mk_win(100, 101, 102, 105, 106, 107, 110, 111, 112);
    checks++; if (win_cap[0] !== w) begin errors++; $display("FAIL b2b_first_win: got %h expected %h", win_cap[0], w); end
    checks++; if (win_cnt != 9) begin errors++; $display("FAIL b2b_count: got %0d expected 9", win_cnt); end
    for (int n = 0; n < 9; n++) begin
      w = exp_win(100, n);
      checks++; if (win_cap[n] !== w) begin errors++; $display("FAIL b2b_win%0d: got %h expected %h", n, win_cap[n], w); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_mid_tstart();
    win_t w;
    clear_rec();
    send_start();
    stream(0, W * H, 1'b0, 10);
    checks++; if (win_cnt != 9) begin errors++; $display("FAIL mid_count: got %0d expected 9", win_cnt); end
    for (int n = 0; n < 9; n++) begin
      w = exp_win(0, n);
      checks++; if (win_cap[n] !== w) begin errors++; $display("FAIL mid_win%0d: got %h expected %h", n, win_cap[n], w); end
    end
    $display("test_mid_tstart done");
  endtask

  task automatic test_tstart_on_last();
    int v_hits, b_hits;
    clear_rec();
    send_start();
    stream(0, W * H, 1'b0, W * H - 1);
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL last_tstart_busy: got %b expected 0", busy_end); end
    checks++; if (win_cnt != 9 || fd_cnt != 1) begin errors++; $display("FAIL last_tstart_frame: got %0d windows %0d done expected 9 1", win_cnt, fd_cnt); end
    v_hits = 0;
    b_hits = 0;
    for (int k = 0; k < 2 * W + 2; k++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(50 + k);
      step();
      if (win_valid !== 1'b0) v_hits++;
      if (busy !== 1'b0) b_hits++;
    end
    pix_valid = 1'b0;
    checks++; if (v_hits != 0 || b_hits != 0) begin errors++; $display("FAIL last_tstart_ignored: got %0d valid %0d busy expected 0 0", v_hits, b_hits); end
    $display("test_tstart_on_last done");
  endtask

  initial begin
    rst_n     = 1'b0;
    tstart    = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    test_reset();
    test_no_tstart();
    test_full_frame();
    test_gaps();
    test_async_reset();
    test_back_to_back();
    test_mid_tstart();
    test_tstart_on_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 32, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per row (>=3).
REQ-003 SHALL have parameter IMG_H, default 64, rows per frame (>=3).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port tstart  input  1  frame-start pulse.
REQ-007 SHALL have port pix_valid  input  1  pix_data is valid this cycle.
REQ-008 SHALL have port pix_data  input  DATA_W  raster-order pixel.
REQ-009 SHALL have port win_data  output  [2:0][2:0] x DATA_W  3x3 window, registered.
REQ-010 SHALL have port win_valid  output  1  win_data holds a new window; drives the downstream averager's tstart.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 SHALL implement states IDLE and STREAM.
- IDLE: busy=0; pix_valid ignored; tstart=1 -> STREAM with col=0, row=0.
- STREAM: busy=1; tstart ignored.
REQ-014 SHALL accept a pixel on every STREAM cycle with pix_valid=1; gaps (pix_valid=0) SHALL freeze all counters, buffers and the window.
REQ-015 SHALL keep col in 0..IMG_W-1 and row in 0..IMG_H-1.
- col increments per accepted pixel and wraps to 0 at IMG_W-1.
- row increments on each col wrap.
REQ-016 SHALL keep two line buffers of IMG_W entries each: lb0 = previous row, lb1 = row before that.
- On acceptance at column c: lb1[c]<=lb0[c], lb0[c]<=pix_data.
REQ-017 SHALL, on each accepted pixel, shift the window left one column and load the new column.
- Row order: win_data[0][2]<=lb1[c], win_data[1][2]<=lb0[c], win_data[2][2]<=pix_data.
- Column order: [i][0] is the oldest column and [i][2] the newest.
REQ-018 SHALL pulse win_valid one cycle after accepting the pixel at (row>=2, col>=2); at all other times win_valid SHALL be 0.
- The window is then centered at (row-1, col-1).
- Latency: one cycle.
REQ-019 SHALL produce exactly (IMG_H-2)*(IMG_W-2) win_valid pulses per frame and SHALL never produce a window that spans a row boundary.
REQ-020 SHALL, on accepting pixel (IMG_H-1, IMG_W-1):
- pulse frame_done the next cycle, coincident with the last win_valid;
- return to IDLE in that same cycle, so busy=0.
REQ-021 SHALL hold win_data between win_valid pulses (no change without an accepted pixel).
REQ-022 SHALL handle tstart coincident with the final pixel as follows: the final pixel completes the frame and tstart is ignored; a new frame requires tstart while in IDLE.
REQ-023 SHALL treat all arithmetic as unsigned; counters SHALL be sized $clog2 of the dimension, with no overflow beyond the wrap points.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-frame, immediately force:
- state=IDLE, col=0, row=0;
- win_valid=0, frame_done=0, busy=0;
- win_data all zero.
REQ-025 SHALL NOT reset line-buffer contents; stale data SHALL never be visible, because of REQ-018 gating.
REQ-026 SHALL, after rst_n deasserts, require tstart before accepting pixels.

Verification (IMG_W=IMG_H=5, pixel value = row*5+col)
REQ-027 SHALL cover: tstart then 25 back-to-back pixels -> exactly 9 win_valid pulses; the first follows pixel 12 with win_data rows {0,1,2},{5,6,7},{10,11,12}; the last has rows {12,13,14},{17,18,19},{22,23,24}; frame_done coincides with the last pulse.
REQ-028 SHALL cover: the same frame with random pix_valid gaps -> identical 9 windows in the same order; win_data stable during gaps.
REQ-029 SHALL cover: pixels presented with no tstart -> no win_valid; busy=0.
REQ-030 SHALL cover: rst_n low after pixel 13 -> win_valid, busy and win_data are 0 asynchronously; a following full frame yields the same 9 correct windows.
REQ-031 SHALL cover: two frames, with tstart the cycle after frame_done and second-frame values offset by 100 -> second-frame first window rows {100,101,102},{105,106,107},{110,111,112}; no first-frame data leaks.
REQ-032 SHALL cover: tstart pulsed mid-frame -> ignored; window sequence unchanged.
